// File: rtl/vlsu_axi_txn_limiter.sv
// Outstanding-transaction limiter for the VLSU AXI master port: caps AR/AW bursts,
// holds W until its AW, and tracks sticky error responses. Optional stall counters: VLSU_TXN_LIMITER_PERF_EN.

package vlsu_axi_txn_limiter_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

module vlsu_axi_txn_limiter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic rd_underflow_s,
    input logic wr_underflow_s
);
    rd_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !rd_underflow_s);
    wr_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !wr_underflow_s);
endmodule

module vlsu_axi_txn_limiter #(
    parameter int unsigned MaxReadTxns  = 8,
    parameter int unsigned MaxWriteTxns = 8,
    parameter type axi_req_t  = vlsu_axi_txn_limiter_pkg::axi_req_t,
    parameter type axi_resp_t = vlsu_axi_txn_limiter_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    input  logic      clear_err_i,
    output logic      rd_idle_o,
    output logic      wr_idle_o,
    output logic      rd_err_o,
`ifdef VLSU_TXN_LIMITER_PERF_EN
    output logic [31:0] ar_stall_cnt_o,
    output logic [31:0] aw_stall_cnt_o,
    output logic        wr_err_o
`else
    output logic        wr_err_o
`endif
);
    localparam int unsigned RdCntW = $clog2(MaxReadTxns + 1);
    localparam int unsigned WrCntW = $clog2(MaxWriteTxns + 1);
    localparam logic [RdCntW-1:0] RdZero = {RdCntW{1'b0}};
    localparam logic [RdCntW-1:0] RdOne  = RdCntW'(32'd1);
    localparam logic [RdCntW-1:0] RdMax  = RdCntW'(MaxReadTxns);
    localparam logic [WrCntW-1:0] WrZero = {WrCntW{1'b0}};
    localparam logic [WrCntW-1:0] WrOne  = WrCntW'(32'd1);
    localparam logic [WrCntW-1:0] WrMax  = WrCntW'(MaxWriteTxns);

    logic [RdCntW-1:0] rd_cnt_r, rd_cnt_s;
    logic [WrCntW-1:0] wr_cnt_r, wr_cnt_s, w_pend_r, w_pend_s;
    logic rd_idle_r, wr_idle_r, rd_err_r, wr_err_r, rd_err_s, wr_err_s;
    logic ar_gate_s, aw_gate_s, w_gate_s;
    logic ar_hs_s, aw_hs_s, w_last_hs_s, r_hs_s, r_last_hs_s, b_hs_s;

    // Gates decode registered counts only, so no valid->ready loop and no retraction of a presented valid
    assign ar_gate_s   = (rd_cnt_r < RdMax);
    assign aw_gate_s   = (wr_cnt_r < WrMax);
    assign ar_hs_s     = slv_req_i.ar_valid & ar_gate_s & mst_resp_i.ar_ready;
    assign aw_hs_s     = slv_req_i.aw_valid & aw_gate_s & mst_resp_i.aw_ready;
    assign w_gate_s    = (w_pend_r != WrZero) | aw_hs_s;
    assign w_last_hs_s = slv_req_i.w_valid & w_gate_s & mst_resp_i.w_ready & slv_req_i.w.last;
    assign r_hs_s      = mst_resp_i.r_valid & slv_req_i.r_ready;
    assign r_last_hs_s = r_hs_s & mst_resp_i.r.last;
    assign b_hs_s      = mst_resp_i.b_valid & slv_req_i.b_ready;

    // Payload pass-through with gated AR/AW/W handshakes
    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_gate_s;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_gate_s;
        mst_req_o.w_valid   = slv_req_i.w_valid & w_gate_s;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_gate_s;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_gate_s;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_gate_s;
    end

    // Next-state counters (underflow holds at zero) and sticky errors (set beats clear)
    always_comb begin
        rd_cnt_s = rd_cnt_r;
        wr_cnt_s = wr_cnt_r;
        w_pend_s = w_pend_r;
        if (ar_hs_s && !r_last_hs_s) begin
            rd_cnt_s = rd_cnt_r + RdOne;
        end else if (!ar_hs_s && r_last_hs_s && (rd_cnt_r != RdZero)) begin
            rd_cnt_s = rd_cnt_r - RdOne;
        end else begin
            rd_cnt_s = rd_cnt_r;
        end
        if (aw_hs_s && !b_hs_s) begin
            wr_cnt_s = wr_cnt_r + WrOne;
        end else if (!aw_hs_s && b_hs_s && (wr_cnt_r != WrZero)) begin
            wr_cnt_s = wr_cnt_r - WrOne;
        end else begin
            wr_cnt_s = wr_cnt_r;
        end
        if (aw_hs_s && !w_last_hs_s) begin
            w_pend_s = w_pend_r + WrOne;
        end else if (!aw_hs_s && w_last_hs_s && (w_pend_r != WrZero)) begin
            w_pend_s = w_pend_r - WrOne;
        end else begin
            w_pend_s = w_pend_r;
        end
        rd_err_s = (r_hs_s & mst_resp_i.r.resp[1]) | (rd_err_r & ~clear_err_i);
        wr_err_s = (b_hs_s & mst_resp_i.b.resp[1]) | (wr_err_r & ~clear_err_i);
    end

    // Tracking state; idle flags are registered from the next counts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_r  <= RdZero;
            wr_cnt_r  <= WrZero;
            w_pend_r  <= WrZero;
            rd_idle_r <= 1'b1;
            wr_idle_r <= 1'b1;
            rd_err_r  <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            rd_cnt_r  <= rd_cnt_s;
            wr_cnt_r  <= wr_cnt_s;
            w_pend_r  <= w_pend_s;
            rd_idle_r <= (rd_cnt_s == RdZero);
            wr_idle_r <= (wr_cnt_s == WrZero) && (w_pend_s == WrZero);
            rd_err_r  <= rd_err_s;
            wr_err_r  <= wr_err_s;
        end
    end

    assign rd_idle_o = rd_idle_r;
    assign wr_idle_o = wr_idle_r;
    assign rd_err_o  = rd_err_r;
    assign wr_err_o  = wr_err_r;

`ifdef VLSU_TXN_LIMITER_PERF_EN
    logic [31:0] ar_stall_r, aw_stall_r;

    // Saturating counts of cycles a request was held off by a full limiter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_stall_r <= 32'd0;
            aw_stall_r <= 32'd0;
        end else if (clear_err_i) begin
            ar_stall_r <= 32'd0;
            aw_stall_r <= 32'd0;
        end else begin
            if (slv_req_i.ar_valid && !ar_gate_s && (ar_stall_r != 32'hFFFF_FFFF)) begin
                ar_stall_r <= ar_stall_r + 32'd1;
            end else begin
                ar_stall_r <= ar_stall_r;
            end
            if (slv_req_i.aw_valid && !aw_gate_s && (aw_stall_r != 32'hFFFF_FFFF)) begin
                aw_stall_r <= aw_stall_r + 32'd1;
            end else begin
                aw_stall_r <= aw_stall_r;
            end
        end
    end

    assign ar_stall_cnt_o = ar_stall_r;
    assign aw_stall_cnt_o = aw_stall_r;
`else
`endif

    vlsu_axi_txn_limiter_chk u_chk (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rd_underflow_s (r_last_hs_s & (rd_cnt_r == RdZero)),
        .wr_underflow_s (b_hs_s & (wr_cnt_r == WrZero))
    );
endmodule

// File: doc/vlsu_axi_txn_limiter.md
Name: vlsu_axi_txn_limiter

Overview:
- Sits directly downstream of the vector load/store unit's AXI master port (after its output cut), between Ara's VLSU and the system interconnect.
- Caps outstanding read and write transactions, forbids W beats from running ahead of their AW, and tracks sticky AXI error responses.
- Zero-latency pass-through on all payloads; only valid/ready handshakes are gated.

Parameters:
MaxReadTxns, 8, max outstanding AR bursts (AR accepted, last R not yet received); >=1
MaxWriteTxns, 8, max outstanding AW bursts (AW accepted, B not yet received); >=1
axi_req_t, logic, AXI request struct type (same as VLSU)
axi_resp_t, logic, AXI response struct type (same as VLSU)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
slv_req_i  in  axi_req_t  request from VLSU
slv_resp_o  out  axi_resp_t  response to VLSU
mst_req_o  out  axi_req_t  request to interconnect
mst_resp_i  in  axi_resp_t  response from interconnect
clear_err_i  in  1  clears both sticky error flags
rd_idle_o  out  1  no outstanding reads
wr_idle_o  out  1  no outstanding writes, no pending W bursts
rd_err_o  out  1  sticky: some R beat had resp[1]=1 (SLVERR/DECERR)
wr_err_o  out  1  sticky: some B had resp[1]=1

Behaviour:
- Single clock domain: clk_i; reset rst_ni, asynchronous, active-low.
- Reset: all counters 0, rd_err_o=0, wr_err_o=0, rd_idle_o=1, wr_idle_o=1.
- Mid-operation reset drops all tracking; the environment must reset the interconnect together with this block.
- Pass-through:
  - All payload fields (ar, aw, w, r, b) go straight through, combinationally.
  - r_valid, b_valid, r_ready, b_ready are ungated.
- Counters:
  - rd_cnt: width $clog2(MaxReadTxns+1). +1 on mst AR handshake; -1 on R handshake with r.last. Both in the same cycle gives a net change of 0.
  - wr_cnt: same width rule with MaxWriteTxns. +1 on AW handshake; -1 on B handshake.
  - w_pend: counts AWs accepted minus W bursts completed (W handshake with w.last). Same width as wr_cnt. Simultaneous inc/dec gives 0.
- AR gating:
  - ar_gate = (rd_cnt < MaxReadTxns).
  - mst ar_valid = slv ar_valid & ar_gate; slv ar_ready = mst ar_ready & ar_gate.
  - The gate depends only on registered state, so there is no valid->ready combinational loop.
  - Once ar_valid is presented downstream, the gate cannot close before that handshake, so AXI valid stability is preserved.
- AW gating: aw_gate = (wr_cnt < MaxWriteTxns); applied to aw_valid/aw_ready in the same way as AR.
- W gating:
  - w_gate = (w_pend != 0) | (AW handshake in the current cycle). Applied to w_valid/w_ready.
  - W may share a cycle with its own AW, but never precede it.
- Full boundary: at rd_cnt==MaxReadTxns, AR is held off. A last-R retiring in the same cycle does not open the gate until the next cycle. AW is handled identically.
- Underflow (protocol violation): a last-R with rd_cnt==0, or a B with wr_cnt==0, leaves the counter at 0. A simulation assertion fires.
- rd_idle_o = (rd_cnt==0). wr_idle_o = (wr_cnt==0) & (w_pend==0). Both are registered-state decodes.
- Errors:
  - rd_err_o sets on an R handshake with r.resp[1]; wr_err_o sets on a B handshake with b.resp[1].
  - clear_err_i clears both flags next cycle.
  - If a set and clear_err_i coincide, set wins (flag stays 1).

Optional Feature:
- Macro VLSU_TXN_LIMITER_PERF_EN.
- Defined:
  - Adds outputs ar_stall_cnt_o and aw_stall_cnt_o (32 b each).
  - Each increments every cycle slv valid=1 and the respective gate=0, and saturates at 2^32-1.
  - Both are cleared by clear_err_i; reset value 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- MaxReadTxns=4; 6 back-to-back ARs (len=0), interconnect withholds R -> exactly 4 ARs pass, 5th held with slv ar_ready=0; one last-R -> 5th AR passes next cycle, rd_cnt stays 4.
- 4 outstanding reads; last-R and a new AR in the same cycle -> AR not accepted (gate closed), rd_cnt=3 next cycle, AR accepted the following cycle.
- VLSU drives W (len=3) two cycles before AW -> mst w_valid=0 until the AW handshake cycle; 4 beats forwarded, w_pend back to 0 after w.last, wr_idle_o=1 once B returns.
- MaxWriteTxns=2; 3 AWs, B withheld -> 3rd AW blocked; B with resp=2'b10 -> wr_err_o=1 and 3rd AW accepted; clear_err_i pulse -> wr_err_o=0.
- R beat with resp=2'b11 in the same cycle as clear_err_i=1 -> rd_err_o=1 afterwards.
- Reset asserted with rd_cnt=3, w_pend=1 -> counters 0 and idle outputs 1 immediately, without waiting for a clock edge; with VLSU_TXN_LIMITER_PERF_EN, 10 blocked AR cycles -> ar_stall_cnt_o=10.
